// File: rtl/morse_pkg.sv
// Shared Morse definitions: slot field widths, unit timing and the player FSM states.
package morse_pkg;

    localparam int unsigned CODE_W    = 4;
    localparam int unsigned LEN_W     = 3;
    localparam int unsigned MAX_ELEMS = 4;

    localparam int unsigned DOT_UNITS      = 1;
    localparam int unsigned DASH_UNITS     = 3;
    localparam int unsigned ELEM_GAP_UNITS = 1;
    localparam int unsigned CHAR_GAP_UNITS = 3;

    localparam int unsigned UNITS_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_ELEM_GAP,
        ST_CHAR_GAP,
        ST_FINISH
    } state_e;

    // Units-remaining preload for a mark; the counter holds units minus one.
    function automatic logic [UNITS_W-1:0] mark_rem(input logic is_dash);
        return is_dash ? UNITS_W'(DASH_UNITS - 1) : UNITS_W'(DOT_UNITS - 1);
    endfunction

    // Out-of-range element counts play as a full four-element character.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_ELEMS)) ? LEN_W'(MAX_ELEMS) : len;
    endfunction

endpackage

// File: rtl/morse_tx_player_if.sv
// Control and status bundle between the message source and the Morse player.
interface morse_tx_player_if #(
    parameter int unsigned NUM_CHARS = 8
);
    import morse_pkg::*;

    localparam int unsigned IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

    logic                        start;
    logic                        abort;
    logic [NUM_CHARS*CODE_W-1:0] codes;
    logic [NUM_CHARS*LEN_W-1:0]  lengths;
    logic                        key;
    logic                        busy;
    logic                        done;
    logic [IDX_W-1:0]            char_idx;

    modport master (
        output start, abort, codes, lengths,
        input  key, busy, done, char_idx
    );

    modport slave (
        input  start, abort, codes, lengths,
        output key, busy, done, char_idx
    );

endinterface

// File: rtl/morse_unit_timer.sv
// Morse unit prescaler: pulses unit_tick_o on the last cycle of every unit, restarted by clear_i.
module morse_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 25_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic unit_tick_o
);

    localparam int unsigned CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Tick is precomputed from the next count so it stays registered even at one cycle per unit.
    always_comb begin
        cnt_d  = (clear_i || tick_q) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign unit_tick_o = tick_q;

endmodule

// File: rtl/morse_tx_player.sv
// Plays a latched packed Morse message onto the key line with standard unit timing.
module morse_tx_player
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 25_000_000,
    parameter int unsigned NUM_CHARS   = 8
) (
    input  logic             clock,
    input  logic             reset,
    morse_tx_player_if.slave bus
);

    localparam int unsigned IDX_W  = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int unsigned ELEM_W = $clog2(MAX_ELEMS);

    state_e                           state_q, state_d;
    logic [NUM_CHARS-1:0][CODE_W-1:0] codes_q, codes_d, codes_in;
    logic [NUM_CHARS-1:0][LEN_W-1:0]  lens_q, lens_d, lens_in;
    logic [IDX_W-1:0]                 char_q, char_d, char_nxt;
    logic [ELEM_W-1:0]                elem_q, elem_d;
    logic [UNITS_W-1:0]               rem_q, rem_d;
    logic                             key_q, key_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;

    logic             unit_tick;
    logic             playing;
    logic             span_done;
    logic             more_elems;
    logic             next_live;
    logic [CODE_W-1:0] cur_code;

    assign codes_in = bus.codes;
    assign lens_in  = bus.lengths;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .clear_i    (!playing),
        .unit_tick_o(unit_tick)
    );

    // Slot bookkeeping derived from the latched message.
    always_comb begin
        playing    = (state_q == ST_MARK) || (state_q == ST_ELEM_GAP) || (state_q == ST_CHAR_GAP);
        span_done  = unit_tick && (rem_q == '0);
        char_nxt   = char_q + IDX_W'(1);
        cur_code   = codes_q[char_q];
        more_elems = (LEN_W'(elem_q) + LEN_W'(1)) < clamp_len(lens_q[char_q]);
        next_live  = (char_q != IDX_W'(NUM_CHARS - 1)) && (lens_q[char_nxt] != '0);
    end

    always_comb begin
        state_d = state_q;
        codes_d = codes_q;
        lens_d  = lens_q;
        char_d  = char_q;
        elem_d  = elem_q;
        rem_d   = rem_q;
        if (unit_tick && (rem_q != '0)) begin
            rem_d = rem_q - UNITS_W'(1);
        end

        if (bus.abort && playing) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FINISH: begin
                    state_d = ST_IDLE;
                    if (bus.start) begin
                        codes_d = codes_in;
                        lens_d  = lens_in;
                        char_d  = '0;
                        elem_d  = '0;
                        if (lens_in[0] != '0) begin
                            state_d = ST_MARK;
                            rem_d   = mark_rem(codes_in[0][0]);
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end
                end
                ST_MARK: begin
                    if (span_done) begin
                        if (more_elems) begin
                            state_d = ST_ELEM_GAP;
                            elem_d  = elem_q + ELEM_W'(1);
                            rem_d   = UNITS_W'(ELEM_GAP_UNITS - 1);
                        end else if (next_live) begin
                            state_d = ST_CHAR_GAP;
                            rem_d   = UNITS_W'(CHAR_GAP_UNITS - 1);
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end
                end
                ST_ELEM_GAP: begin
                    if (span_done) begin
                        state_d = ST_MARK;
                        rem_d   = mark_rem(cur_code[elem_q]);
                    end
                end
                ST_CHAR_GAP: begin
                    if (span_done) begin
                        state_d = ST_MARK;
                        char_d  = char_nxt;
                        elem_d  = '0;
                        rem_d   = mark_rem(codes_q[char_nxt][0]);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        key_d  = (state_d == ST_MARK);
        busy_d = (state_d == ST_MARK) || (state_d == ST_ELEM_GAP) || (state_d == ST_CHAR_GAP);
        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            codes_q <= '0;
            lens_q  <= '0;
            char_q  <= '0;
            elem_q  <= '0;
            rem_q   <= '0;
            key_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            codes_q <= codes_d;
            lens_q  <= lens_d;
            char_q  <= char_d;
            elem_q  <= elem_d;
            rem_q   <= rem_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.key      = key_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.char_idx = char_q;

endmodule

// File: tb/tb_morse_tx_player.sv
// Bench for morse_tx_player: directed and random messages against a cycle-list Morse model.
module tb_morse_tx_player;

    localparam int unsigned U = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    morse_tx_player_if #(.NUM_CHARS(8)) bus ();

    morse_tx_player #(
        .UNIT_CYCLES(U),
        .NUM_CHARS  (8)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit exp_key[$];
    int exp_idx[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected key level and char_idx for cycles 1..T, built straight from the Morse timing rules.
    function automatic void build(input logic [31:0] c, input logic [23:0] l);
        exp_key.delete();
        exp_idx.delete();
        for (int s = 0; s < 8; s++) begin
            int n;
            n = int'(l[3*s +: 3]);
            if (n > 4) n = 4;
            if (n == 0) break;
            if (s > 0) begin
                repeat (3 * U) begin exp_key.push_back(1'b0); exp_idx.push_back(s - 1); end
            end
            for (int j = 0; j < n; j++) begin
                if (j > 0) begin
                    repeat (U) begin exp_key.push_back(1'b0); exp_idx.push_back(s); end
                end
                repeat ((c[4*s + j] ? 3 : 1) * U) begin
                    exp_key.push_back(1'b1);
                    exp_idx.push_back(s);
                end
            end
        end
    endfunction

    // ctl_kind: 0 none, 1 abort at cycle ctl_at, 2 reset at cycle ctl_at, 3 abort asserted with start.
    task automatic play(input logic [31:0] c, input logic [23:0] l, input int ctl_at,
                        input int ctl_kind, input bit hold, input bit chained, input string nm);
        int t;
        build(c, l);
        t = exp_key.size();
        if (!chained) begin
            @(negedge clk);
            bus.codes   = c;
            bus.lengths = l;
            bus.start   = 1'b1;
            bus.abort   = (ctl_kind == 3);
        end
        @(posedge clk); #1;
        bus.start = hold;
        bus.abort = 1'b0;
        for (int k = 1; k <= t; k++) begin
            chk({nm, ":key"},  32'(bus.key),      32'(exp_key[k-1]));
            chk({nm, ":busy"}, 32'(bus.busy),     32'd1);
            chk({nm, ":idx"},  32'(bus.char_idx), 32'(exp_idx[k-1]));
            chk({nm, ":done"}, 32'(bus.done),     32'd0);
            if (k == ctl_at && (ctl_kind == 1 || ctl_kind == 2)) begin
                if (ctl_kind == 1) bus.abort = 1'b1;
                else               rst       = 1'b1;
                @(posedge clk); #1;
                bus.abort = 1'b0;
                rst       = 1'b0;
                chk({nm, ":ctl_idx"}, 32'(bus.char_idx), (ctl_kind == 1) ? 32'(exp_idx[k-1]) : 32'd0);
                repeat (2 * U) begin
                    chk({nm, ":ctl_key"},  32'(bus.key),  32'd0);
                    chk({nm, ":ctl_busy"}, 32'(bus.busy), 32'd0);
                    chk({nm, ":ctl_done"}, 32'(bus.done), 32'd0);
                    @(posedge clk); #1;
                end
                return;
            end
            bus.codes   = (k == t) ? c : $urandom;
            bus.lengths = (k == t) ? l : 24'($urandom);
            @(posedge clk); #1;
        end
        chk({nm, ":end_done"}, 32'(bus.done), 32'd1);
        chk({nm, ":end_key"},  32'(bus.key),  32'd0);
        chk({nm, ":end_busy"}, 32'(bus.busy), 32'd0);
        if (t > 0) chk({nm, ":end_idx"}, 32'(bus.char_idx), 32'(exp_idx[t-1]));
        if (hold) return;
        @(posedge clk); #1;
        chk({nm, ":post_done"}, 32'(bus.done), 32'd0);
        chk({nm, ":post_key"},  32'(bus.key),  32'd0);
        chk({nm, ":post_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] rc;
        logic [23:0] rl;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.codes   = '0;
        bus.lengths = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key",  32'(bus.key),      32'd0);
        chk("rst_busy", 32'(bus.busy),     32'd0);
        chk("rst_done", 32'(bus.done),     32'd0);
        chk("rst_idx",  32'(bus.char_idx), 32'd0);
        rst = 1'b0;

        play(32'h0,         24'o1,        0, 0, 1'b0, 1'b0, "E");
        play(32'h2,         24'o2,        0, 0, 1'b0, 1'b0, "A");
        play(32'h10,        24'o11,       0, 0, 1'b0, 1'b0, "ET");
        play(32'hFFFF_FFFF, 24'o44444444, 0, 0, 1'b0, 1'b0, "FULL");
        play(32'h0,         24'o0,        0, 0, 1'b0, 1'b0, "EMPTY");
        play(32'hF0,        24'o30,       0, 0, 1'b0, 1'b0, "SLOT0_ZERO");
        play(32'hABCD_1234, 24'o77777777, 0, 0, 1'b0, 1'b0, "CLAMP");
        play(32'h2,         24'o2,       14, 1, 1'b0, 1'b0, "ABORT");
        play(32'h2,         24'o2,        0, 0, 1'b1, 1'b0, "HOLD");
        play(32'h2,         24'o2,        0, 0, 1'b0, 1'b1, "CHAIN");
        play(32'h10,        24'o11,      25, 2, 1'b0, 1'b0, "RESET");
        play(32'h0,         24'o1,        0, 3, 1'b0, 1'b0, "IDLE_ABORT");

        for (int n = 0; n < 20; n++) begin
            rc = $urandom;
            rl = '0;
            for (int s = 0; s < 8; s++) begin
                int v;
                v = int'($urandom_range(1, 7));
                if ($urandom_range(0, 7) == 0) v = 0;
                rl[3*s +: 3] = 3'(v);
            end
            play(rc, rl, 0, 0, 1'b0, 1'b0, "RAND");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
